// File: rtl/fp_mul_result_collector.sv
// fp_mul_result_collector: tags multiplier issues, buffers results in a
// FIFO and hands them downstream as packed IEEE-754 words.
module fp_mul_result_collector #(
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             iss_valid,
  input  logic [TAG_W-1:0] iss_tag,
  output logic             iss_ready,
  input  logic             Sz,
  input  logic [7:0]       Ez,
  input  logic [22:0]      Mz,
  input  logic [4:0]       mul_flags,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [4:0]       res_flags,
  output logic [TAG_W-1:0] res_tag,
  output logic [4:0]       sticky,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] res_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(LAT + DEPTH + 1);

  typedef struct packed {
    logic [31:0]      data;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [LAT-1:0]   pv;
  logic [TAG_W-1:0] pt [LAT];

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;

  logic [SW-1:0] inflight;
  logic          issue;
  logic          cap;
  logic          pop;
  logic          full;
  logic          wr_en;
  entry_t        head;
  entry_t        cap_e;

  // Count issues still travelling through the multiplier.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++)
      inflight = inflight + SW'(pv[i]);
  end

  // Credit, capture and pop decisions for this cycle.
  always_comb begin
    iss_ready = (inflight + SW'(occ)) < SW'(DEPTH);
    issue     = iss_valid & iss_ready;
    cap       = pv[LAT-1];
    full      = occ == (AW+1)'(DEPTH);
    res_valid = occ != '0;
    pop       = res_valid & res_ready;
    wr_en     = cap & (~full | pop);
    cap_e     = {Sz, Ez, Mz, mul_flags, pt[LAT-1]};
    head      = mem[rd_ptr];
  end

  // Head of the FIFO is presented only while it holds data.
  always_comb begin
    res_data  = '0;
    res_flags = '0;
    res_tag   = '0;
    if (res_valid) begin
      res_data  = head.data;
      res_flags = head.flags;
      res_tag   = head.tag;
    end
  end

  // Tag pipeline mirroring the fixed multiplier latency.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++)
        pt[i] <= '0;
    end else begin
      pv[0] <= issue;
      pt[0] <= iss_tag;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pt[i] <= pt[i-1];
      end
    end
  end

  // Result storage; contents are qualified by occ, so no reset.
  always_ff @(posedge CLK) begin
    if (wr_en)
      mem[wr_ptr] <= cap_e;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Sticky exception flags; a capture in the clear cycle survives.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      sticky <= '0;
    else
      sticky <= (sticky_clr ? 5'b0 : sticky)
              | (cap ? mul_flags : 5'b0);
  end

  // Saturating count of results handed downstream.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      res_count <= '0;
    else if (pop && res_count != '1)
      res_count <= res_count + 1'b1;
  end

  // Credits make a capture into a full, non-popping FIFO impossible.
  always @(posedge CLK) begin
    if (!RST)
      assert (!(cap && full && !pop))
        else $error("capture into full FIFO dropped");
  end

endmodule

// File: tb/tb_fp_mul_result_collector.sv
// tb_fp_mul_result_collector: table vectors plus a scoreboard queue
// for the multiplier result collector.
`timescale 1ns/1ps
module tb_fp_mul_result_collector;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CNT_W = 4;
  localparam int NV    = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             iss_valid;
  logic [TAG_W-1:0] iss_tag;
  logic             iss_ready;
  logic             Sz;
  logic [7:0]       Ez;
  logic [22:0]      Mz;
  logic [4:0]       mul_flags;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [4:0]       res_flags;
  logic [TAG_W-1:0] res_tag;
  logic [4:0]       sticky;
  logic             sticky_clr;
  logic [CNT_W-1:0] res_count;

  always #5 CLK = ~CLK;

  fp_mul_result_collector #(
    .LAT   (LAT),
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .iss_valid  (iss_valid),
    .iss_tag    (iss_tag),
    .iss_ready  (iss_ready),
    .Sz         (Sz),
    .Ez         (Ez),
    .Mz         (Mz),
    .mul_flags  (mul_flags),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_flags  (res_flags),
    .res_tag    (res_tag),
    .sticky     (sticky),
    .sticky_clr (sticky_clr),
    .res_count  (res_count)
  );

  typedef struct {
    logic [31:0] p;
    logic [4:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0]      d;
    logic [4:0]       f;
    logic [TAG_W-1:0] t;
  } exp_t;

  typedef struct {
    bit          drv;
    bit          live;
    logic [31:0] d;
    logic [4:0]  f;
  } mul_t;

  vec_t vt [NV];
  exp_t sbq [$];
  mul_t mp [LAT];

  int checks = 0;
  int errors = 0;
  int exp_occ;
  int pops;
  logic [CNT_W-1:0] exp_cnt;
  logic [4:0]       exp_sticky;
  logic [TAG_W-1:0] next_tag;
  bit issue_on;
  bit last_acc;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s", nm, why);
  endtask

  task automatic clear_model();
    sbq.delete();
    exp_occ    = 0;
    exp_cnt    = '0;
    exp_sticky = '0;
    next_tag   = '0;
    pops       = 0;
    for (int k = 0; k < LAT; k++)
      mp[k].live = 1'b0;
  endtask

  // One clock: drive, check current outputs, predict, advance.
  task automatic tick();
    exp_t e;
    int   infl;
    bit   acc;
    bit   pp;
    bit   cp;
    iss_valid = issue_on;
    iss_tag   = next_tag;
    infl = 0;
    for (int k = 0; k < LAT; k++)
      if (mp[k].live) infl++;
    chk("iss_ready", iss_ready, (infl + exp_occ) < DEPTH);
    chk("res_valid", res_valid, exp_occ != 0);
    chk("sticky", sticky, exp_sticky);
    chk("res_count", res_count, exp_cnt);
    if (exp_occ == 0) begin
      chk("empty_data", res_data, 0);
      chk("empty_flags", res_flags, 0);
      chk("empty_tag", res_tag, 0);
    end else if (sbq.size() == 0) begin
      fail("scoreboard", "got output, want none pending");
    end else begin
      chk("head_data", res_data, sbq[0].d);
      chk("head_flags", res_flags, sbq[0].f);
      chk("head_tag", res_tag, sbq[0].t);
    end
    acc = iss_valid && iss_ready && !RST;
    pp  = res_valid && res_ready && !RST;
    cp  = mp[LAT-1].live && !RST;
    if (!RST) begin
      if (pp) begin
        if (sbq.size() > 0)
          e = sbq.pop_front();
        pops++;
        if (exp_cnt != '1)
          exp_cnt = exp_cnt + 1'b1;
      end
      if (acc) begin
        e.d = vt[next_tag % NV].p;
        e.f = vt[next_tag % NV].f;
        e.t = next_tag;
        sbq.push_back(e);
      end
      exp_sticky = (sticky_clr ? 5'b0 : exp_sticky)
                 | (cp ? mp[LAT-1].f : 5'b0);
      exp_occ = exp_occ + int'(cp) - int'(pp);
    end
    last_acc = acc;
    @(posedge CLK);
    #1;
    for (int k = LAT - 1; k > 0; k--)
      mp[k] = mp[k-1];
    mp[0].drv  = acc;
    mp[0].live = acc;
    mp[0].d    = vt[next_tag % NV].p;
    mp[0].f    = vt[next_tag % NV].f;
    if (acc)
      next_tag = next_tag + 1'b1;
    if (mp[LAT-1].drv) begin
      {Sz, Ez, Mz} = mp[LAT-1].d;
      mul_flags    = mp[LAT-1].f;
    end else begin
      {Sz, Ez, Mz} = $urandom;
      mul_flags    = 5'($urandom);
    end
  endtask

  task automatic do_reset();
    issue_on   = 1'b0;
    res_ready  = 1'b0;
    sticky_clr = 1'b0;
    RST = 1'b1;
    #1;
    clear_model();
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc_n;
    int seen;
    logic [4:0] all_f;

    // 3*2, 1*1, -2*3, inf*0, min*min, max*2, 1.5*1.5, 0.1f*10
    vt[0] = '{32'h40C00000, 5'b00000};
    vt[1] = '{32'h3F800000, 5'b00000};
    vt[2] = '{32'hC0C00000, 5'b00000};
    vt[3] = '{32'h7FFFFFFF, 5'b10000};
    vt[4] = '{32'h00000000, 5'b00101};
    vt[5] = '{32'h7F800000, 5'b01010};
    vt[6] = '{32'h40100000, 5'b00000};
    vt[7] = '{32'h3F800000, 5'b00010};

    iss_valid  = 1'b0;
    iss_tag    = '0;
    Sz         = 1'b0;
    Ez         = '0;
    Mz         = '0;
    mul_flags  = '0;
    res_ready  = 1'b0;
    sticky_clr = 1'b0;
    issue_on   = 1'b0;
    for (int k = 0; k < LAT; k++)
      mp[k] = '{1'b0, 1'b0, 32'h0, 5'h0};
    clear_model();

    // Reset state
    #1 RST = 1'b1;
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_iss_ready", iss_ready, 1);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_flags", res_flags, 0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_res_count", res_count, 0);
    @(posedge CLK);
    #1;
    do_reset();

    // Table vectors, one at a time
    all_f = '0;
    for (int i = 0; i < NV; i++) begin
      next_tag = TAG_W'(i);
      issue_on = 1'b1;
      tick();
      issue_on = 1'b0;
      n = 0;
      while (!res_valid && n < 20) begin
        tick();
        n++;
      end
      chk("t1_latency", n, LAT);
      chk("t1_data", res_data, vt[i].p);
      chk("t1_flags", res_flags, vt[i].f);
      chk("t1_tag", res_tag, i);
      all_f = all_f | vt[i].f;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
    tick();
    chk("t1_sticky_all", sticky, all_f);
    chk("t1_count", res_count, NV);

    // Backpressure: exactly DEPTH issues get credit
    do_reset();
    issue_on = 1'b1;
    acc_n = 0;
    repeat (10) begin
      tick();
      acc_n += int'(last_acc);
    end
    issue_on = 1'b0;
    chk("t2_accepted", acc_n, DEPTH);
    chk("t2_iss_ready", iss_ready, 0);
    res_ready = 1'b1;
    repeat (DEPTH + LAT + 4) tick();
    res_ready = 1'b0;
    chk("t2_pops", pops, DEPTH);
    chk("t2_count", res_count, 4);

    // Sticky flags and clear with simultaneous capture
    do_reset();
    res_ready = 1'b1;
    next_tag  = 4'd3;
    issue_on  = 1'b1;
    tick();
    tick();
    issue_on = 1'b0;
    repeat (LAT + 3) tick();
    chk("t3_sticky", sticky, 5'b10101);
    next_tag = 4'd5;
    issue_on = 1'b1;
    tick();
    issue_on = 1'b0;
    repeat (LAT - 1) tick();
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("t3_sticky_clr", sticky, 5'b01010);
    repeat (3) tick();
    res_ready = 1'b0;

    // Fill, then pop and capture in the same cycle
    do_reset();
    issue_on = 1'b1;
    n = 0;
    while (exp_occ != DEPTH && n < 30) begin
      tick();
      n++;
    end
    issue_on = 1'b0;
    if (n >= 30)
      fail("t4_fill", "got no full FIFO, want full");
    tick();
    chk("t4_full_ready", iss_ready, 0);
    chk("t4_full_valid", res_valid, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    issue_on = 1'b1;
    tick();
    issue_on = 1'b0;
    chk("t4_refill_acc", last_acc, 1);
    chk("t4_refill_ready", iss_ready, 0);
    repeat (LAT - 1) tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t4_after_ready", iss_ready, 1);
    chk("t4_after_valid", res_valid, 1);
    res_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    res_ready = 1'b0;
    chk("t4_pops", pops, DEPTH + 1);
    chk("t4_sb_empty", sbq.size(), 0);

    // Reset with work in flight and buffered
    do_reset();
    issue_on = 1'b1;
    tick();
    tick();
    issue_on = 1'b0;
    repeat (LAT) tick();
    issue_on = 1'b1;
    tick();
    tick();
    issue_on = 1'b0;
    chk("t5_pre_ready", iss_ready, 0);
    chk("t5_pre_valid", res_valid, 1);
    RST = 1'b1;
    #1;
    chk("t5_rst_valid", res_valid, 0);
    chk("t5_rst_ready", iss_ready, 1);
    chk("t5_rst_data", res_data, 0);
    clear_model();
    tick();
    RST = 1'b0;
    res_ready = 1'b1;
    seen = 0;
    repeat (LAT + 6) begin
      tick();
      if (res_valid)
        seen++;
    end
    chk("t5_no_late", seen, 0);
    res_ready = 1'b0;

    // Streaming: pointer wrap and count saturation
    do_reset();
    res_ready = 1'b1;
    issue_on  = 1'b1;
    n = 0;
    while (pops < 20 && n < 300) begin
      tick();
      n++;
    end
    issue_on = 1'b0;
    if (n >= 300)
      fail("t6_stream", "got timeout, want 20 pops");
    repeat (LAT + DEPTH + 2) tick();
    chk("t6_count", res_count, (1 << CNT_W) - 1);
    chk("t6_sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
